// File: rtl/btn_debouncer_pkg.sv
// Shared constants for the push-button debouncer: state encoding and default intervals.
// BTN_AUTO_REPEAT_EN adds the MCEN_ST/REPT auto-repeat states to the encoding.
package btn_debouncer_pkg;

  localparam int unsigned DB_CYCLES_DEF     = 1000000;
  localparam int unsigned HOLD_CYCLES_DEF   = 50000000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10000000;

  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    HOLD    = 3'd3,
`ifdef BTN_AUTO_REPEAT_EN
    MCEN_ST = 3'd4,
    REPT    = 3'd5,
`endif
    WFCR    = 3'd6
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input; reusable for any async pin.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button debouncer with single-press (scen) and auto-repeat (mcen) enables.
// Define BTN_AUTO_REPEAT_EN to enable auto-repeat; otherwise mcen mirrors scen.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic db_level,
  output logic scen,
  output logic mcen
);

  localparam int unsigned CNT_MAX = max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             btn_sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

  // One counter is shared by every timed state; each state entry restarts it from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INI: begin
        cnt_nxt = '0;
        if (btn_sync) state_nxt = WQ;
      end
      WQ: begin
        if (!btn_sync) begin
          state_nxt = INI;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = SCEN_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SCEN_ST: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      HOLD: begin
        if (!btn_sync) begin
          state_nxt = WFCR;
          cnt_nxt   = '0;
`ifdef BTN_AUTO_REPEAT_EN
        end else if (cnt == HOLD_LAST) begin
          state_nxt = MCEN_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`else
        end else begin
          cnt_nxt = '0;
        end
`endif
      end
`ifdef BTN_AUTO_REPEAT_EN
      MCEN_ST: begin
        state_nxt = REPT;
        cnt_nxt   = '0;
      end
      REPT: begin
        if (!btn_sync) begin
          state_nxt = WFCR;
          cnt_nxt   = '0;
        end else if (cnt == REPT_LAST) begin
          state_nxt = MCEN_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      WFCR: begin
        // A high glitch during release restarts the whole release interval.
        if (btn_sync) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = INI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = INI;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INI;
      cnt      <= '0;
      db_level <= 1'b0;
      scen     <= 1'b0;
      mcen     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      db_level <= (state_nxt != INI) && (state_nxt != WQ);
      scen     <= (state_nxt == SCEN_ST);
`ifdef BTN_AUTO_REPEAT_EN
      mcen     <= (state_nxt == SCEN_ST) || (state_nxt == MCEN_ST);
`else
      mcen     <= (state_nxt == SCEN_ST);
`endif
    end
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Self-checking bench for btn_debouncer against a run-length/timestamp model of the button.
// Honours BTN_AUTO_REPEAT_EN the same way as the design.
module tb_btn_debouncer;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic db_level, scen, mcen;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  btn_debouncer #(
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .db_level (db_level),
    .scen     (scen),
    .mcen     (mcen)
  );

  always #5 clk = ~clk;

  // Model: idle until DB+1 consecutive synced highs; pulses are timed by edges since acceptance;
  // release completes after DB consecutive synced lows.
  typedef enum {M_IDLE, M_PRESSED, M_RELEASE} mode_t;
  mode_t mode = M_IDLE;
  int hi_run = 0, lo_run = 0, age = 0;
  bit s1 = 0, s2 = 0;
  bit exp_db = 0, exp_scen = 0, exp_mcen = 0;

  function automatic bit pulse_at(input int e);
    if (e == 0) return 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
    if (e >= HOLD + 1 && ((e - (HOLD + 1)) % (REP + 1)) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit s;
    s = s2;
    if (rst) begin
      s1 = 0; s2 = 0; mode = M_IDLE; hi_run = 0; lo_run = 0; age = 0;
      exp_db = 0; exp_scen = 0; exp_mcen = 0;
    end else begin
      s2 = s1;
      s1 = btn_in;
      exp_scen = 0;
      exp_mcen = 0;
      case (mode)
        M_IDLE: begin
          hi_run = s ? hi_run + 1 : 0;
          if (hi_run == DB + 1) begin
            mode = M_PRESSED; age = 0; exp_scen = 1; exp_mcen = 1;
          end
        end
        M_PRESSED: begin
          age++;
          if (age >= 2 && !s && !pulse_at(age - 1)) begin
            mode = M_RELEASE; lo_run = 0;
          end else if (pulse_at(age)) begin
            exp_mcen = 1;
          end
        end
        M_RELEASE: begin
          lo_run = s ? 0 : lo_run + 1;
          if (lo_run == DB) begin
            mode = M_IDLE; hi_run = 0;
          end
        end
        default: mode = M_IDLE;
      endcase
      exp_db = (mode != M_IDLE);
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_db_level", db_level, exp_db);
      checkOutput("model_scen", scen, exp_scen);
      checkOutput("model_mcen", mcen, exp_mcen);
    end
  end

  task automatic applyStimulus(input logic r, input logic b, input int n);
    rst    = r;
    btn_in = b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int scen_cnt, mcen_cnt, waited;
    rst = 1'b1;
    btn_in = 1'b0;
    applyStimulus(1'b1, 1'b0, 3);
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_db_level", db_level, 1'b0);
    checkOutput("reset_scen", scen, 1'b0);
    checkOutput("reset_mcen", mcen, 1'b0);

    // Clean press held 40 cycles: edge 0 is the first edge sampling btn_in=1.
    applyStimulus(1'b0, 1'b0, 4);
    btn_in = 1'b1;
    scen_cnt = 0;
    mcen_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      scen_cnt += int'(scen);
      mcen_cnt += int'(mcen);
      if (i == 5) checkOutput("press_scen_before_edge6", scen, 1'b0);
      if (i == 5) checkOutput("press_db_before_edge6", db_level, 1'b0);
      if (i == 6) checkOutput("press_scen_edge6", scen, 1'b1);
      if (i == 6) checkOutput("press_mcen_edge6", mcen, 1'b1);
      if (i == 6) checkOutput("press_db_edge6", db_level, 1'b1);
      if (i == 7) checkOutput("press_scen_edge7", scen, 1'b0);
      if (i == 30) checkOutput("press_db_held", db_level, 1'b1);
`ifdef BTN_AUTO_REPEAT_EN
      if (i == 16) checkOutput("repeat_mcen_edge16", mcen, 1'b0);
      if (i == 17) checkOutput("repeat_mcen_edge17", mcen, 1'b1);
      if (i == 20) checkOutput("repeat_mcen_edge20", mcen, 1'b0);
      if (i == 21) checkOutput("repeat_mcen_edge21", mcen, 1'b1);
      if (i == 25) checkOutput("repeat_mcen_edge25", mcen, 1'b1);
`else
      if (i == 17) checkOutput("norepeat_mcen_edge17", mcen, 1'b0);
`endif
    end
    tests++;
    if (scen_cnt != 1) begin
      fails++;
      $display("[TB] FAIL press_scen_count: got %0d expected 1", scen_cnt);
    end
    tests++;
`ifdef BTN_AUTO_REPEAT_EN
    if (mcen_cnt != 7) begin
      fails++;
      $display("[TB] FAIL press_mcen_count: got %0d expected 7", mcen_cnt);
    end
`else
    if (mcen_cnt != 1) begin
      fails++;
      $display("[TB] FAIL press_mcen_count: got %0d expected 1", mcen_cnt);
    end
`endif

    // Release with a one-cycle high glitch in the middle of the release interval.
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 12);

    // Bounce while qualifying: exactly one scen afterwards.
    scen_cnt = 0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_in = (i == 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      scen_cnt += int'(scen);
    end
    tests++;
    if (scen_cnt != 1) begin
      fails++;
      $display("[TB] FAIL bounce_scen_count: got %0d expected 1", scen_cnt);
    end
    applyStimulus(1'b0, 1'b0, 12);

    // Reset during the scen cycle, then during the hold/repeat phase.
    for (int pass = 0; pass < 2; pass++) begin
      rst = 1'b0;
      btn_in = 1'b1;
      waited = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        waited++;
      end while (scen !== 1'b1 && waited < 20);
      tests++;
      if (scen !== 1'b1) begin
        fails++;
        $display("[TB] FAIL rst_wait_scen: got %b expected 1 within 20 cycles", scen);
      end
      if (pass == 1) repeat (14) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_mid_db_level", db_level, 1'b0);
      checkOutput("rst_mid_scen", scen, 1'b0);
      checkOutput("rst_mid_mcen", mcen, 1'b0);
      rst = 1'b0;
      repeat (5) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_no_scen", scen, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 10);
      applyStimulus(1'b0, 1'b0, 12);
    end

    // Randomized runs of high/low levels with occasional resets.
    for (int n = 0; n < 250; n++) begin
      logic lvl, r;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
      r = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
      applyStimulus(r, lvl, r ? 1 : len);
    end
    applyStimulus(1'b0, 1'b0, 10);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter DB_CYCLES, default 1000000: press/release debounce interval in clk cycles (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter HOLD_CYCLES, default 50000000: hold time after press acceptance before the first auto-repeat; legal range >= 2.
REQ-003 Parameter REPEAT_CYCLES, default 10000000: auto-repeat period; legal range >= 2.
REQ-004 clk  in  1  board clock (ClkPort); all state changes on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high (BtnC at top level).
REQ-006 btn_in  in  1  raw asynchronous push-button level (BtnU/D/L/R).
REQ-007 db_level  out  1  debounced button level.
REQ-008 scen  out  1  single-clock enable; one-cycle pulse per accepted press.
REQ-009 mcen  out  1  multiple-clock enable; one-cycle pulse at press acceptance and at each auto-repeat.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchroniser; only the second-flop output (btn_sync) SHALL drive the FSM.
REQ-011 FSM states SHALL be INI, WQ, SCEN_ST, HOLD, MCEN_ST, REPT, WFCR; one shared counter, width fitting the largest parameter.
REQ-012 INI: counter=0; btn_sync=1 -> WQ.
REQ-013 WQ: btn_sync=0 -> INI, counter=0; counter==DB_CYCLES-1 -> SCEN_ST, counter=0; otherwise counter+1.
REQ-014 SCEN_ST: scen=1 and mcen=1 for exactly this cycle; unconditionally -> HOLD, counter=0; btn_sync ignored.
REQ-015 HOLD: btn_sync=0 -> WFCR, counter=0; counter==HOLD_CYCLES-1 -> MCEN_ST; otherwise counter+1.
REQ-016 MCEN_ST: mcen=1 for this cycle only; -> REPT, counter=0.
REQ-017 REPT: btn_sync=0 -> WFCR, counter=0; counter==REPEAT_CYCLES-1 -> MCEN_ST; otherwise counter+1.
REQ-018 WFCR: btn_sync=1 -> counter=0, stay (release glitch restarts the interval); counter==DB_CYCLES-1 -> INI; otherwise counter+1.
REQ-019 db_level SHALL be 1 in SCEN_ST, HOLD, MCEN_ST, REPT, WFCR and 0 in INI, WQ; all outputs decoded from registered state (Moore).
REQ-020 Latency: with edge k the first edge sampling btn_in=1 and btn_in held high, scen SHALL be high in the cycle after edge k+DB_CYCLES+2.
REQ-021 A bounce low in WQ for any number of cycles SHALL return to INI and restart the full debounce interval.
REQ-022 scen and mcen SHALL never be high for two consecutive cycles.

Reset
REQ-023 rst=1 at a clock edge SHALL force state INI, counter=0, synchroniser flops=0, db_level=scen=mcen=0 in the following cycle, from any state including mid-count or pulse cycles.
REQ-024 After rst deasserts with btn_in already high, a full press debounce from INI SHALL be required before scen.

Configuration
REQ-025 Macro BTN_AUTO_REPEAT_EN: defined -> REQ-015..017 as written; undefined -> HOLD ignores HOLD_CYCLES and leaves only on release (to WFCR), MCEN_ST/REPT unreachable and removed, mcen identical to scen.

Structure
REQ-026 Package btn_debouncer_pkg SHALL hold the state encoding constants and the default values of DB_CYCLES, HOLD_CYCLES and REPEAT_CYCLES.
REQ-027 The synchroniser SHALL be sub-module sync_2ff (clk, rst, d, q), reusable for other async inputs such as the accelerometer MISO line.

Verification (DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, macro defined unless noted)
REQ-028 Clean press held 40 cycles from edge 0 -> scen/mcen high in the cycle after edge 6; db_level high from then on; mcen repeats every 4 cycles after the HOLD interval.
REQ-029 Bounce 1,1,0,1,1,1,1,1 in WQ -> no scen until 4 consecutive btn_sync=1 cycles following the last low; exactly one scen.
REQ-030 Release with one-cycle high glitch mid-WFCR -> db_level stays 1 until 4 consecutive lows after the glitch, then 0; no extra scen.
REQ-031 rst pulsed during REPT and during the SCEN_ST cycle -> all outputs 0 in the next cycle, state INI, no pulse emitted afterwards until a new debounced press.
REQ-032 Macro undefined, press held 40 cycles -> exactly one scen and one mcen, same cycle; no repeats.
